// File: rtl/serial_word_receiver_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_receiver_pkg
//  Description : Shared types and constants for the serial word receiver:
//                FSM state encoding and bit-order selector values.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_word_receiver_pkg;

    // Receiver framing state
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_e;

    // Bit-order selector values carried alongside the SOF bit
    localparam logic MSB_FIRST_C = 1'b1;
    localparam logic LSB_FIRST_C = 1'b0;

endpackage : serial_word_receiver_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock circular-buffer FIFO with occupancy counter.
//                Push while full is ignored unless a pop occurs on the same
//                edge; pop while empty is ignored. Head word is read straight
//                from the storage registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_full,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [WIDTH-1:0] w_mem_d [DEPTH];
    logic [AW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [AW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [CW-1:0]    r_count_q,  w_count_d;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count_q == c_depth);
    assign o_empty = (r_count_q == '0);
    assign o_rdata = r_mem_q[r_rd_ptr_q];

    // Qualify push/pop and compute next pointers, occupancy and storage
    always_comb begin
        w_pop      = i_pop && !o_empty;
        w_push     = i_push && (!o_full || w_pop);
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (w_push) begin
            w_mem_d[r_wr_ptr_q] = i_wdata;
            w_wr_ptr_d          = r_wr_ptr_q + AW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + AW'(1);
        end
        if (w_push && !w_pop) begin
            w_count_d = r_count_q + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count_q - CW'(1);
        end
    end

    // State registers; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_mem_q    <= w_mem_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : serial_word_receiver
//  Description : Reassembles SOF-framed serial bits into WIDTH-bit words in
//                either bit order and queues them in a small FIFO presented
//                on a valid/ready interface. Flags frame errors (FERR pulse)
//                and dropped words (sticky OVF).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             CLR_L,
    input  logic             SIN,
    input  logic             SEN,
    input  logic             SOF,
    input  logic             MSB_FIRST,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             OVF,
    output logic             FERR
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] c_last = CW'(WIDTH);

    rx_state_e        r_state_q, w_state_d;
    logic [CW-1:0]    r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0] r_sr_q,    w_sr_d;
    logic             r_order_q, w_order_d;
    logic             r_ferr_q,  w_ferr_d;
    logic             r_ovf_q,   w_ovf_d;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    // Framing FSM: bit capture, counting, word completion and frame errors
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_sr_d    = r_sr_q;
        w_order_d = r_order_q;
        w_ferr_d  = 1'b0;
        w_push    = 1'b0;
        if (SEN) begin
            if (SOF) begin
                // An SOF inside a word abandons it; the bit starts a new word
                w_ferr_d  = (r_state_q == SHIFT);
                w_order_d = MSB_FIRST;
                w_cnt_d   = CW'(1);
                w_state_d = SHIFT;
                if (MSB_FIRST == MSB_FIRST_C) begin
                    w_sr_d = {{(WIDTH-1){1'b0}}, SIN};
                end else begin
                    w_sr_d = {SIN, {(WIDTH-1){1'b0}}};
                end
            end else if (r_state_q == SHIFT) begin
                if (r_order_q == MSB_FIRST_C) begin
                    w_sr_d = {r_sr_q[WIDTH-2:0], SIN};
                end else begin
                    w_sr_d = {SIN, r_sr_q[WIDTH-1:1]};
                end
                w_cnt_d = r_cnt_q + CW'(1);
                if (w_cnt_d == c_last) begin
                    w_push    = 1'b1;
                    w_state_d = IDLE;
                    w_cnt_d   = '0;
                end
            end
        end
    end

    // A completed word is lost only when the FIFO is full and not draining
    assign w_drop = w_push && w_full && !(DREADY && !w_empty);

    // Sticky overflow accumulation
    always_comb begin
        w_ovf_d = r_ovf_q | w_drop;
    end

    // Receiver state registers
    always_ff @(posedge CLK) begin
        if (!CLR_L) begin
            r_state_q <= IDLE;
            r_cnt_q   <= '0;
            r_sr_q    <= '0;
            r_order_q <= MSB_FIRST_C;
            r_ferr_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_sr_q    <= w_sr_d;
            r_order_q <= w_order_d;
            r_ferr_q  <= w_ferr_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (CLR_L),
        .i_push  (w_push),
        .i_wdata (w_sr_d),
        .o_full  (w_full),
        .i_pop   (DREADY),
        .o_rdata (DOUT),
        .o_empty (w_empty)
    );

    assign DVALID = !w_empty;
    assign OVF    = r_ovf_q;
    assign FERR   = r_ferr_q;

endmodule : serial_word_receiver
`default_nettype wire

// File: doc/serial_word_receiver.md
# serial_word_receiver

Receiving end of the serial link driven by a universal shift register run as a parallel-in/serial-out transmitter. Samples one bit per qualified clock and reassembles framed serial bits into WIDTH-bit words, in either bit order. Completed words are buffered in a small FIFO and presented on a valid/ready interface. It sits between the serial pin and the parallel consumer logic.

## Interface
- WIDTH, 4: bits per word; legal values are 2 to 16.
- DEPTH, 2: number of output FIFO entries; must be a power of two, at least 2.
- CLK  input  1  clock; all state changes on the rising edge.
- CLR_L  input  1  reset, synchronous, active-low.
- SIN  input  1  serial data bit.
- SEN  input  1  bit strobe; SIN is sampled on edges where SEN=1.
- SOF  input  1  start of frame; qualified only with SEN=1; marks the first bit of a word.
- MSB_FIRST  input  1  bit order, sampled with the SOF bit. 1: first bit lands in DOUT[WIDTH-1]. 0: first bit lands in DOUT[0].
- DOUT  output  WIDTH  head word of the FIFO.
- DVALID  output  1  FIFO is not empty.
- DREADY  input  1  consumer accepts; pop happens when DVALID&&DREADY.
- OVF  output  1  sticky overflow flag; cleared only by reset.
- FERR  output  1  one-cycle pulse on a frame error.

## Operation
- Reset (CLR_L=0 at an edge):
  - State goes to IDLE, the bit counter goes to 0, and the shift register is cleared.
  - FIFO is emptied.
  - DOUT=0, DVALID=0, OVF=0, FERR=0.
  - A reset mid-word discards the partial word.
- FSM states: IDLE and SHIFT.
  - IDLE with SEN&&SOF: latch MSB_FIRST, store bit 0, set count=1, go to SHIFT. With WIDTH bits done in one bit (not legal, since WIDTH≥2) no special case is needed.
  - IDLE with SEN&&!SOF: bit ignored; no error.
  - SHIFT with SEN&&!SOF: store the bit and increment count. If count reaches WIDTH, push the word and return to IDLE.
  - SHIFT with SEN&&SOF: pulse FERR and discard the partial word. This bit starts a new word: count=1, stay in SHIFT.
  - SHIFT with SEN=0: hold. There is no timeout; gaps of any length are legal.
- Assembly:
  - MSB-first: shift left, SIN enters bit 0. After WIDTH bits, the first bit is in DOUT[WIDTH-1].
  - LSB-first: shift right, SIN enters bit WIDTH-1. After WIDTH bits, the first bit is in DOUT[0].
- FIFO:
  - Circular buffer with wrapping read and write pointers and an occupancy counter of width clog2(DEPTH)+1.
  - Push when full: the word is dropped and OVF is set, unless a pop occurs on the same edge. In that case both are performed and the occupancy is unchanged.
  - Push and pop on the same edge when not full or empty: both are performed.
  - Pop when empty: ignored.

## Timing
- Latency: the word is visible on DOUT with DVALID=1 on the edge after the edge that sampled its last bit (1 cycle), when the FIFO was empty.
- DOUT and DVALID are registered. DOUT is held stable while DVALID=1 and DREADY=0.
- FERR is asserted for exactly the one cycle after the offending edge.
- OVF rises the cycle after the dropped push.
- Maximum throughput is one bit per clock. Back-to-back words are legal: the SOF of the next word may immediately follow the last bit.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE=1'b0, SHIFT=1'b1);
  - the bit-order constants MSB_FIRST_C=1'b1 and LSB_FIRST_C=1'b0.
- One sub-module: `sync_fifo` (parameters WIDTH, DEPTH; push/full, pop/empty), which other receivers can reuse.
- The top level contains the FSM, the bit counter, and the shift register.

## Test plan
- MSB-first word: with WIDTH=4, send bits 1,0,1,1 (SOF on the first bit). Expect DOUT=4'b1011 and DVALID=1 one cycle after the fourth bit. Pulse DREADY and expect DVALID=0.
- LSB-first word: send bits 1,0,1,1 with MSB_FIRST=0. Expect DOUT=4'b1101. Insert SEN=0 gaps of 3 cycles between bits and expect the same result.
- Frame error: send SOF,1,0, then SOF,0,0,1,1. Expect FERR to pulse once, and a single word DOUT=4'b0011.
- Overflow: with DEPTH=2 and DREADY=0, send words 0x3, 0x5, 0x9.
  - Expect 0x3 then 0x5 to be delivered and 0x9 to be lost.
  - Expect OVF=1, held until reset.
  - Repeat the sequence with DREADY=1 on the third word's completion edge. Expect no OVF, and all three words delivered.
- Reset mid-word: after 2 bits, drive CLR_L=0 for one edge. Expect all outputs 0. Then send a full word 0xA and expect only 0xA delivered.
- Stray bits: SEN pulses without SOF while in IDLE. Expect no push, no FERR, DVALID=0.
